// File: rtl/flux_sched_pkg.sv
// Shared types and helpers for the round-robin flux scheduler.
// Widths are bounded by MAX_FLUX and 32-bit counters.
package flux_sched_pkg;

  typedef enum logic {IDLE, OWNED} sched_state_t;

  localparam int MAX_FLUX = 32;

  // Index of the first ready flux after start (start itself last), or -1.
  function automatic int rr_next(
    logic [MAX_FLUX-1:0] ready,
    int                  start,
    int                  nflux
  );
    int r;
    r = -1;
    for (int k = nflux; k >= 1; k--) begin
      if (ready[5'((start + k) % nflux)]) r = (start + k) % nflux;
    end
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(
    logic [31:0] v,
    int          w
  );
    logic [31:0] m;
    m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v == m) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/flux_rr_picker.sv
// Rotating priority picker: rotate so start+1 is bit 0,
// take the lowest set bit, rotate the index back.
module flux_rr_picker #(
  parameter int N  = 2,
  parameter int TW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [TW-1:0] start_i,
  output logic          found_o,
  output logic [TW-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             sh;
  int             off;

  always_comb begin
    sh  = (int'(start_i) + 1) % N;
    dbl = {req_i, req_i};
    rot = N'(dbl >> sh);
    off = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    found_o = |rot;
    idx_o   = TW'((sh + off) % N);
  end

endmodule

// File: rtl/flux_rr_scheduler.sv
// Bounded-burst round-robin grant for multi-flux actors,
// with per-flux saturating fire counters.
module flux_rr_scheduler #(
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = $clog2(FLUX),
  parameter int BURST     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 flush,
  input  logic [FLUX-1:0]      ready,
  output logic                 grant_valid,
  output logic [TAG_WIDTH-1:0] grant_tag,
  output logic [FLUX-1:0]      grant_onehot,
  input  logic [TAG_WIDTH-1:0] cnt_sel,
  output logic [CNT_WIDTH-1:0] cnt_out
);
  import flux_sched_pkg::*;

  localparam int BW = $clog2(BURST + 1);

  sched_state_t         state_q, state_d;
  logic [TAG_WIDTH-1:0] owner_q, owner_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic [CNT_WIDTH-1:0] fire_cnt_q [FLUX];
  logic [CNT_WIDTH-1:0] fire_cnt_d [FLUX];

  logic                 pick_found;
  logic [TAG_WIDTH-1:0] pick_idx;
  logic                 gv;
  logic [TAG_WIDTH-1:0] gtag;

  flux_rr_picker #(
    .N  (FLUX),
    .TW (TAG_WIDTH)
  ) u_pick (
    .req_i   (ready),
    .start_i (owner_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    gv      = 1'b0;
    gtag    = '0;
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    if (flush) begin
      state_d = IDLE;
      owner_d = TAG_WIDTH'(FLUX - 1);
      burst_d = '0;
    end else if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            gv      = 1'b1;
            gtag    = pick_idx;
            state_d = OWNED;
            owner_d = pick_idx;
            burst_d = BW'(1);
          end
        end
        OWNED: begin
          if (ready[owner_q] && int'(burst_q) < BURST) begin
            gv      = 1'b1;
            gtag    = owner_q;
            burst_d = burst_q + BW'(1);
          end else if (pick_found) begin
            gv      = 1'b1;
            gtag    = pick_idx;
            owner_d = pick_idx;
            burst_d = BW'(1);
          end else begin
            // Owner kept as the rotation pointer for the next pick.
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      fire_cnt_d[i] = fire_cnt_q[i];
      if (gv && gtag == TAG_WIDTH'(i)) begin
        fire_cnt_d[i] = CNT_WIDTH'(sat_inc(32'(fire_cnt_q[i]), CNT_WIDTH));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= TAG_WIDTH'(FLUX - 1);
      burst_q    <= '0;
      fire_cnt_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      fire_cnt_q <= fire_cnt_d;
    end
  end

  assign grant_valid  = gv & rst_n;
  assign grant_tag    = (gv && rst_n) ? gtag : '0;
  assign grant_onehot = (gv && rst_n) ? (FLUX'(1) << gtag) : '0;
  assign cnt_out      = (int'(cnt_sel) < FLUX) ? fire_cnt_q[cnt_sel] : '0;

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Directed bench for flux_rr_scheduler with a cycle-level
// reference model checked on every falling edge.
module tb_flux_rr_scheduler;

  localparam int FLUX = 4;
  localparam int TW   = 2;
  localparam int BURST = 2;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic [FLUX-1:0] ready = '0;
  logic          grant_valid;
  logic [TW-1:0] grant_tag;
  logic [FLUX-1:0] grant_onehot;
  logic [TW-1:0] cnt_sel = '0;
  logic [CW-1:0] cnt_out;

  int checks = 0;
  int errors = 0;

  flux_rr_scheduler #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TW),
    .BURST     (BURST),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .flush        (flush),
    .ready        (ready),
    .grant_valid  (grant_valid),
    .grant_tag    (grant_tag),
    .grant_onehot (grant_onehot),
    .cnt_sel      (cnt_sel),
    .cnt_out      (cnt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the flux, how many beats it has had,
  // whether anyone owns it at all, and how often each flux fired.
  bit m_has_owner;
  int m_owner;
  int m_beats;
  int m_cnt [FLUX];

  function automatic int next_ready_after(int start);
    for (int k = 1; k <= FLUX; k++) begin
      if (ready[(start + k) % FLUX]) return (start + k) % FLUX;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_has_owner = 0;
    m_owner = FLUX - 1;
    m_beats = 0;
    for (int i = 0; i < FLUX; i++) m_cnt[i] = 0;
  endtask

  always @(negedge clk) begin
    bit e_v;
    int e_tag;
    int p;
    e_v = 0;
    e_tag = 0;
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      m_has_owner = 0;
      m_owner = FLUX - 1;
      m_beats = 0;
    end else if (enable) begin
      if (m_has_owner && ready[m_owner] && m_beats < BURST) begin
        e_v = 1;
        e_tag = m_owner;
        m_beats++;
      end else begin
        p = next_ready_after(m_owner);
        if (p >= 0) begin
          e_v = 1;
          e_tag = p;
          m_owner = p;
          m_beats = 1;
          m_has_owner = 1;
        end else begin
          m_has_owner = 0;
        end
      end
    end
    chk("m_valid", grant_valid, e_v);
    chk("m_tag", grant_tag, e_tag);
    chk("m_onehot", grant_onehot, e_v ? (1 << e_tag) : 0);
    chk("m_cnt", cnt_out, rst_n ? m_cnt[cnt_sel] : 0);
    if (e_v && m_cnt[e_tag] < CMAX) m_cnt[e_tag]++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    enable = 1'b0;
    flush = 1'b0;
    ready = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int rot_seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  int ef_seq [5] = '{0, 0, 1, 1, 2};

  initial begin
    model_reset();
    do_reset();

    for (int s = 0; s < FLUX; s++) begin
      step();
      enable = 1'b1;
      ready = '0;
      cnt_sel = TW'(s);
      #2;
      chk("rst_valid", grant_valid, 0);
      chk("rst_cnt", cnt_out, 0);
    end

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      enable = 1'b1;
      ready = 4'b1111;
      #2;
      chk("rot_valid", grant_valid, 1);
      chk("rot_tag", grant_tag, rot_seq[i]);
    end

    do_reset();
    cnt_sel = 2'd2;
    for (int i = 0; i < 5; i++) begin
      step();
      enable = 1'b1;
      ready = 4'b0100;
      #2;
      chk("single_tag", grant_tag, 2);
      chk("single_onehot", grant_onehot, 4'b0100);
    end
    step();
    ready = '0;
    #2;
    chk("single_cnt", cnt_out, 5);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      enable = 1'b1;
      ready = 4'b1111;
      #2;
      chk("ef_tag", grant_tag, ef_seq[i]);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      enable = 1'b0;
      #2;
      chk("ef_off_valid", grant_valid, 0);
    end
    step();
    enable = 1'b1;
    #2;
    chk("ef_resume_tag", grant_tag, 2);
    step();
    flush = 1'b1;
    #2;
    chk("ef_flush_valid", grant_valid, 0);
    step();
    flush = 1'b0;
    #2;
    chk("ef_after_flush_valid", grant_valid, 1);
    chk("ef_after_flush_tag", grant_tag, 0);

    do_reset();
    cnt_sel = 2'd1;
    for (int i = 0; i < 20; i++) begin
      step();
      enable = 1'b1;
      ready = 4'b0010;
    end
    step();
    ready = '0;
    #2;
    chk("sat_cnt", cnt_out, 15);

    do_reset();
    cnt_sel = 2'd3;
    step();
    enable = 1'b1;
    ready = 4'b1000;
    #2;
    chk("ar_first_tag", grant_tag, 3);
    step();
    #2;
    chk("ar_burst_tag", grant_tag, 3);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", grant_valid, 0);
    chk("ar_onehot", grant_onehot, 0);
    chk("ar_tag", grant_tag, 0);
    chk("ar_cnt", cnt_out, 0);
    step();
    rst_n = 1'b1;
    ready = 4'b1010;
    #2;
    chk("ar_release_tag", grant_tag, 1);
    chk("ar_release_valid", grant_valid, 1);

    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
